// File: rtl/shift_r_arb_seq_if.sv
// Bundle for the two requester ports and the result port of shift_r_arb_seq.
// WIDTH must match the WIDTH of the shift_r_arb_seq instance it connects to.
interface shift_r_arb_seq_if #(
    parameter int WIDTH = 8
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_y;
    logic             out_id;

    // Requester/consumer side.
    modport master (
        output req0_valid, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_a, req1_b,
        input  req1_ready,
        input  out_valid, out_y, out_id,
        output out_ready
    );

    // Shift engine side.
    modport slave (
        input  req0_valid, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_a, req1_b,
        output req1_ready,
        output out_valid, out_y, out_id,
        input  out_ready
    );
endinterface

// File: rtl/shift_r_arb_seq.sv
// Two-requester round-robin arbiter in front of a multi-cycle arithmetic
// right shifter. One log-stage (shift by 2^k) is resolved per SHIFT cycle,
// so an operation takes SHIFT_WIDTH cycles regardless of the amount.
module shift_r_arb_seq #(
    parameter int WIDTH       = 8,
    parameter int SHIFT_WIDTH = 3
) (
    input  logic              clk,
    input  logic              rst,
    shift_r_arb_seq_if.slave  bus
);
    localparam int KW = (SHIFT_WIDTH > 1) ? $clog2(SHIFT_WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       acc_q, acc_d;
    logic [SHIFT_WIDTH-1:0] amt_q, amt_d;
    logic [KW-1:0]          k_q, k_d;
    logic                   id_q, id_d;
    logic                   rr_q, rr_d;

    logic                   gnt_any;
    logic                   gnt_id;
    logic [WIDTH-1:0]       stage_y;

    // Grant: a lone requester wins outright, a tie goes to rr_q.
    always_comb begin
        gnt_any = (state_q == IDLE) && !rst && (bus.req0_valid || bus.req1_valid);
        if (bus.req0_valid && bus.req1_valid)
            gnt_id = rr_q;
        else
            gnt_id = bus.req1_valid;
    end

    assign bus.req0_ready = gnt_any && !gnt_id;
    assign bus.req1_ready = gnt_any && gnt_id;

    // The single reused stage: sign-filled shift of acc by 2^k.
    always_comb begin
        stage_y = acc_q;
        for (int i = 0; i < SHIFT_WIDTH; i++) begin
            if (k_q == KW'(i))
                stage_y = $signed(acc_q) >>> (2 ** i);
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        amt_d   = amt_q;
        k_d     = k_q;
        id_d    = id_q;
        rr_d    = rr_q;
        case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    acc_d   = gnt_id ? bus.req1_a : bus.req0_a;
                    amt_d   = gnt_id ? bus.req1_b[SHIFT_WIDTH-1:0]
                                     : bus.req0_b[SHIFT_WIDTH-1:0];
                    id_d    = gnt_id;
                    k_d     = '0;
                    rr_d    = ~gnt_id;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (amt_q[k_q])
                    acc_d = stage_y;
                k_d = k_q + KW'(1);
                if (k_q == KW'(SHIFT_WIDTH - 1))
                    state_d = DONE;
            end
            DONE: begin
                // No grant here: IDLE must be visited before the next accept.
                if (bus.out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset drops any in-flight or pending result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            amt_q   <= '0;
            k_q     <= '0;
            id_q    <= 1'b0;
            rr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            amt_q   <= amt_d;
            k_q     <= k_d;
            id_q    <= id_d;
            rr_q    <= rr_d;
        end
    end

    // acc stays frozen in DONE, so out_y/out_id hold under backpressure.
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_y     = acc_q;
    assign bus.out_id    = id_q;

endmodule

// File: tb/tb_shift_r_arb_seq.sv
// Bench for shift_r_arb_seq: directed scenarios followed by random traffic,
// all checked cycle by cycle against a transaction-level reference model.
module tb_shift_r_arb_seq;
    localparam int W  = 8;
    localparam int SW = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    shift_r_arb_seq_if #(.WIDTH(W)) bus ();

    shift_r_arb_seq #(.WIDTH(W), .SHIFT_WIDTH(SW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Stimulus state: per-requester op queues and the op currently offered.
    logic [15:0] q0[$];
    logic [15:0] q1[$];
    logic [W-1:0] pa[2];
    logic [W-1:0] pb[2];
    bit   pend[2];
    int   gap_pct = 0;
    int   or_mode = 0;
    int   bp_left = 0;
    bit   arm_rst = 0;
    int   rst_at  = -1;
    int   cyc     = 0;

    // Reference model: one operation in flight, fairness by last grant.
    bit          busy      = 0;
    int          g_cyc     = 0;
    int          next_idle = 0;
    int          last_gnt  = 1;
    logic [W-1:0] exp_y;
    logic        exp_id;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    // floor(A / 2^s) on the signed value equals an arithmetic right shift.
    function automatic logic [W-1:0] ref_sra(input logic [W-1:0] a, input logic [W-1:0] b);
        int v, d, q;
        v = (int'(a) >= 128) ? int'(a) - 256 : int'(a);
        d = 1 << (int'(b) % (1 << SW));
        q = v / d;
        if (v < 0 && (v % d) != 0) q = q - 1;
        return q[W-1:0];
    endfunction

    function automatic bit load_ok();
        return ($urandom_range(99) >= gap_pct);
    endfunction

    task automatic run(input int ncyc, input bit until_empty);
        bit done;
        bit exp_ov, idle_ok, sel, r0, r1, v0, v1;
        logic [1:0] exp_rdy;
        done = 0;
        for (int i = 0; i < ncyc && !done; i++) begin
            if (!pend[0] && q0.size() > 0 && load_ok()) begin
                {pa[0], pb[0]} = q0.pop_front(); pend[0] = 1;
            end
            if (!pend[1] && q1.size() > 0 && load_ok()) begin
                {pa[1], pb[1]} = q1.pop_front(); pend[1] = 1;
            end
            bus.req0_valid = pend[0]; bus.req0_a = pa[0]; bus.req0_b = pb[0];
            bus.req1_valid = pend[1]; bus.req1_a = pa[1]; bus.req1_b = pb[1];
            exp_ov = busy && (cyc >= g_cyc + SW + 1);
            case (or_mode)
                0: bus.out_ready = 1'b1;
                1: bus.out_ready = 1'($urandom_range(1));
                default: begin
                    if (exp_ov && bp_left > 0) begin
                        bus.out_ready = 1'b0; bp_left--;
                    end else bus.out_ready = 1'b1;
                end
            endcase
            rst = (cyc < 2) || (cyc == rst_at);
            #1;
            v0 = pend[0]; v1 = pend[1];
            r0 = bus.req0_ready; r1 = bus.req1_ready;
            idle_ok = !busy && !rst && (cyc >= next_idle);
            if (v0 && v1) sel = (last_gnt == 0);
            else          sel = v1;
            exp_rdy = (idle_ok && (v0 || v1)) ? (sel ? 2'b10 : 2'b01) : 2'b00;
            if (cyc > 0) begin
                chk("ready", {30'd0, r1, r0}, {30'd0, exp_rdy});
                chk("out_valid", {31'd0, bus.out_valid}, {31'd0, exp_ov});
                if (exp_ov) begin
                    chk("out_y", {24'd0, bus.out_y}, {24'd0, exp_y});
                    chk("out_id", {31'd0, bus.out_id}, {31'd0, exp_id});
                end
            end
            if (rst) begin
                busy = 0; next_idle = cyc + 1; last_gnt = 1;
            end else begin
                if (exp_ov && bus.out_ready) begin
                    busy = 0; next_idle = cyc + 1;
                end
                if ((r0 && v0) || (r1 && v1)) begin
                    int n;
                    n = (r1 && v1) ? 1 : 0;
                    busy = 1; g_cyc = cyc; last_gnt = n;
                    exp_y = ref_sra(pa[n], pb[n]); exp_id = 1'(n);
                    pend[n] = 0;
                    if (arm_rst) begin rst_at = cyc + 2; arm_rst = 0; end
                end
            end
            @(negedge clk);
            cyc++;
            if (until_empty)
                done = q0.size() == 0 && q1.size() == 0 && !pend[0] && !pend[1] && !busy;
        end
        if (until_empty && !done) chk("drain_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        rst_at = cyc;
        run(1, 0);
    endtask

    initial begin
        pend[0] = 0; pend[1] = 0;
        pa[0] = '0; pa[1] = '0; pb[0] = '0; pb[1] = '0;
        rst = 1'b1;
        bus.req0_valid = 0; bus.req1_valid = 0; bus.out_ready = 0;
        bus.req0_a = '0; bus.req0_b = '0; bus.req1_a = '0; bus.req1_b = '0;

        // Reset state.
        run(3, 0);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_y", {24'd0, bus.out_y}, 32'd0);
        chk("rst_out_id", {31'd0, bus.out_id}, 32'd0);

        // Basic shifts, extremes and a masked amount.
        q0.push_back({8'h80, 8'h03}); q0.push_back({8'h35, 8'h00});
        run(100, 1);
        q1.push_back({8'h7F, 8'h07}); q1.push_back({8'h81, 8'h07});
        run(100, 1);
        q0.push_back({8'h40, 8'hF9});
        run(100, 1);

        // Contention from a fresh reset: grants must alternate 0,1,0,1.
        do_reset();
        q0.push_back({8'h10, 8'h01}); q0.push_back({8'h10, 8'h01});
        q1.push_back({8'hE0, 8'h02}); q1.push_back({8'hE0, 8'h02});
        run(200, 1);

        // Backpressure with a second requester waiting.
        or_mode = 2; bp_left = 5;
        q0.push_back({8'h5A, 8'h02}); q1.push_back({8'h33, 8'h01});
        run(200, 1);
        or_mode = 0;

        // Reset during SHIFT stage k=1, then a tie must go to requester 0.
        arm_rst = 1;
        q0.push_back({8'h22, 8'h03});
        run(100, 1);
        q0.push_back({8'hC0, 8'h02}); q1.push_back({8'h11, 8'h01});
        run(200, 1);

        // Random traffic with gaps and random consumer backpressure.
        gap_pct = 30; or_mode = 1;
        for (int i = 0; i < 40; i++) begin
            q0.push_back(16'($urandom));
            q1.push_back(16'($urandom));
        end
        run(4000, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
